window_feeder: RTL

Streaming 7×7 window generator that drives the `neuron_unit` input side. It accepts a raster-order 8-bit luminance pixel stream, buffers six previous image lines, and emits one 7×7 window per valid pixel position. The window is presented as seven 56-bit row words plus `de_out`, in the same packing `neuron_unit` consumes on `line_0_in`…`line_6_in`/`de_in`.

---
 rtl/window_feeder_pkg.sv | 19 +
 rtl/window_feeder_line_buffer.sv | 31 +++
 rtl/window_feeder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/window_feeder_pkg.sv
// Shared definitions for the 7x7 window feeder.
//   PIX_W  : luminance sample width
//   WIN    : window edge length (rows and columns)
//   LINE_W : packed width of one window row word
//   pix_t  : one luminance sample
//   state_t: sequencer states
package window_pkg;
   localparam int PIX_W  = 8;
   localparam int WIN    = 7;
   localparam int LINE_W = PIX_W * WIN;

   typedef logic [PIX_W-1:0] pix_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } state_t;
endpackage

// File: rtl/window_feeder_line_buffer.sv
// One image line of storage for the window feeder.
// Asynchronous read, synchronous write, single shared address, so a
// read-then-overwrite of the same location happens within one cycle.
// Ports:
//   clk   : clock
//   addr  : column address (read and write)
//   we    : write enable
//   wdata : sample to store
//   rdata : sample currently stored at addr
module line_buffer
   import window_pkg::*;
#(
   parameter int DEPTH = 28,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  pix_t          wdata,
   output pix_t          rdata
);

   pix_t mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/window_feeder.sv
// Streaming 7x7 window generator feeding neuron_unit.
// Takes a raster-order pixel stream, keeps six previous lines in chained
// line buffers and emits one packed 7x7 window per valid position.
// Ports:
//   clk, reset (sync, active low)
//   sof_in, de_in, pixel_in   : pixel stream in (sof qualified by de)
//   line_0_out..line_6_out    : window rows, 0 = oldest, [7:0] = newest column
//   de_out                    : one-cycle window valid
//   frame_done                : pulse with the final window of a frame
//   window_cnt                : windows in current frame (only with
//                               WINDOW_FEEDER_COUNT_EN defined)
//
// state  | meaning
// IDLE   | waiting for sof_in & de_in; other pixels ignored
// FILL   | rows 0..5 being buffered, no windows
// STREAM | row >= 6, window for every pixel with col >= 6
module window_feeder
   import window_pkg::*;
#(
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sof_in,
   input  logic              de_in,
   input  pix_t              pixel_in,
   output logic [LINE_W-1:0] line_0_out,
   output logic [LINE_W-1:0] line_1_out,
   output logic [LINE_W-1:0] line_2_out,
   output logic [LINE_W-1:0] line_3_out,
   output logic [LINE_W-1:0] line_4_out,
   output logic [LINE_W-1:0] line_5_out,
   output logic [LINE_W-1:0] line_6_out,
   output logic              de_out,
   output logic              frame_done
`ifdef WINDOW_FEEDER_COUNT_EN
   ,
   output logic [15:0]       window_cnt
`endif
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(WIN - 1);
   localparam logic [RW-1:0] ROW_PRE   = RW'(WIN - 2);
   localparam int HIST_W = LINE_W - PIX_W;

   state_t        state;
   logic [CW-1:0] col, cur_col;
   logic [RW-1:0] row, cur_row;
   logic          start, accept, col_last, row_last, win_valid, last_pix;

   pix_t              rd       [WIN-1];
   pix_t              row_data [WIN];
   // Six stages of history per row; the live sample is the seventh column.
   logic [HIST_W-1:0] hist     [WIN];
   logic [LINE_W-1:0] win_q    [WIN];

   always_comb begin
      start     = de_in & sof_in;
      accept    = de_in & (sof_in | (state != IDLE));
      // A start pixel is always (0,0), regardless of where the counters are.
      cur_col   = start ? '0 : col;
      cur_row   = start ? '0 : row;
      col_last  = (cur_col == COL_LAST);
      row_last  = (cur_row == ROW_LAST);
      win_valid = accept & ~start & (state == STREAM) & (col >= COL_FIRST);
      last_pix  = accept & ~start & (state == STREAM) & col_last & row_last;
   end

   for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
      pix_t wdata;
      if (k == WIN - 2) begin : g_head
         assign wdata = pixel_in;
      end else begin : g_chain
         assign wdata = rd[k+1];
      end
      line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
         .clk   (clk),
         .addr  (cur_col),
         .we    (accept),
         .wdata (wdata),
         .rdata (rd[k])
      );
      assign row_data[k] = rd[k];
   end
   assign row_data[WIN-1] = pixel_in;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         de_out     <= 1'b0;
         frame_done <= 1'b0;
         for (int k = 0; k < WIN; k++) begin
            hist[k]  <= '0;
            win_q[k] <= '0;
         end
      end else begin
         de_out     <= win_valid;
         frame_done <= last_pix;
         if (accept) begin
            for (int k = 0; k < WIN; k++)
               hist[k] <= {hist[k][HIST_W-PIX_W-1:0], row_data[k]};
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : cur_row + RW'(1);
            end else begin
               col <= cur_col + CW'(1);
               row <= cur_row;
            end
            if (start) begin
               state <= FILL;
            end else begin
               case (state)
                  FILL:    if (col_last && cur_row == ROW_PRE) state <= STREAM;
                  STREAM:  if (col_last && row_last) state <= IDLE;
                  default: state <= state;
               endcase
            end
         end
         if (win_valid) begin
            for (int k = 0; k < WIN; k++)
               win_q[k] <= {hist[k], row_data[k]};
         end
      end
   end

   assign line_0_out = win_q[0];
   assign line_1_out = win_q[1];
   assign line_2_out = win_q[2];
   assign line_3_out = win_q[3];
   assign line_4_out = win_q[4];
   assign line_5_out = win_q[5];
   assign line_6_out = win_q[6];

`ifdef WINDOW_FEEDER_COUNT_EN
   always_ff @(posedge clk) begin
      if (!reset)
         window_cnt <= '0;
      else if (start)
         window_cnt <= '0;
      else if (win_valid && window_cnt != 16'hFFFF)
         window_cnt <= window_cnt + 16'd1;
   end
`endif

endmodule
